// File: rtl/ex_stage_muldiv_pkg.sv
// Shared types for the execute stage: ALU codes, M-extension ops, forwarding selects, mul/div FSM states.
// Optional build macro EX_DIV_EARLY_OUT_EN is consumed by muldiv_unit.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_code_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {FWD_REG, FWD_WB, FWD_MEM} fwd_sel_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;

  // MEM wins outright; WB is considered only when MEM does not match.
  function automatic fwd_sel_e fwd_select(input logic [4:0] rs,
                                          input logic       reg_write_mem,
                                          input logic [4:0] rd_mem,
                                          input logic       reg_write_wb,
                                          input logic [4:0] rd_wb);
    if (reg_write_mem && rd_mem != 5'd0 && rd_mem == rs) return FWD_MEM;
    if (reg_write_wb && rd_wb != 5'd0 && rd_wb == rs) return FWD_WB;
    return FWD_REG;
  endfunction

  function automatic logic op_a_signed(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_b_signed(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/ex_stage_muldiv_muldiv_unit.sv
// Multi-cycle M-extension unit: FSM, latency counter, multiplier and restoring divider.
// EX_DIV_EARLY_OUT_EN: divide-by-zero / overflow skip the divide loop.
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            md_valid,
  input  logic [2:0]      md_op,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state;
  logic [CW-1:0]   cnt;
  md_op_e          op_q;
  logic [XLEN-1:0] a_q, b_q, dvs_q, rem_q, quo_q, result_q;

  md_op_e          cur_op;
  logic [XLEN-1:0] cur_a, cur_b, mag_a, mag_b;
  logic            cur_sa, cur_sb;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0] mul_res;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff, q_nxt, r_nxt, quo_fin, rem_fin, div_res;
  logic            sub_ok, div_zero, div_ovf, early_out;

  // In IDLE the live operands are used so single-cycle outcomes can be resolved at the latch edge.
  always_comb begin
    cur_op  = (state == S_IDLE) ? md_op_e'(md_op) : op_q;
    cur_a   = (state == S_IDLE) ? op_a : a_q;
    cur_b   = (state == S_IDLE) ? op_b : b_q;
    cur_sa  = op_a_signed(cur_op) & cur_a[XLEN-1];
    cur_sb  = op_b_signed(cur_op) & cur_b[XLEN-1];
    mag_a   = cur_sa ? -cur_a : cur_a;
    mag_b   = cur_sb ? -cur_b : cur_b;
    product = {{XLEN{cur_sa}}, cur_a} * {{XLEN{cur_sb}}, cur_b};
    mul_res = (cur_op == MD_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    rem_sh  = {rem_q, quo_q[XLEN-1]};
    sub_ok  = rem_sh >= {1'b0, dvs_q};
    diff    = rem_sh[XLEN-1:0] - dvs_q;
    q_nxt   = {quo_q[XLEN-2:0], sub_ok};
    r_nxt   = sub_ok ? diff : rem_sh[XLEN-1:0];

    div_zero = (cur_b == '0);
    div_ovf  = op_b_signed(cur_op) && (cur_a == MIN_NEG) && (cur_b == '1);
    quo_fin  = (cur_sa ^ cur_sb) ? -q_nxt : q_nxt;
    rem_fin  = cur_sa ? -r_nxt : r_nxt;
    if (div_zero) begin
      quo_fin = '1;
      rem_fin = cur_a;
    end else if (div_ovf) begin
      quo_fin = cur_a;
      rem_fin = '0;
    end
    div_res = (cur_op inside {MD_REM, MD_REMU}) ? rem_fin : quo_fin;
  end

`ifdef EX_DIV_EARLY_OUT_EN
  assign early_out = div_zero | div_ovf;
`else
  assign early_out = 1'b0;
`endif

  // MUL is loaded with MUL_LAT-1 so the total stall, including the latch cycle, is MUL_LAT+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= MD_MUL;
      a_q      <= '0;
      b_q      <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_valid) begin
            op_q  <= cur_op;
            a_q   <= op_a;
            b_q   <= op_b;
            quo_q <= mag_a;
            dvs_q <= mag_b;
            rem_q <= '0;
            if (md_op[2]) begin
              if (early_out) begin
                state    <= S_DONE;
                result_q <= div_res;
              end else begin
                state <= S_DIV;
                cnt   <= CW'(XLEN - 1);
              end
            end else if (MUL_LAT == 0) begin
              state    <= S_DONE;
              result_q <= mul_res;
            end else begin
              state <= S_MUL;
              cnt   <= CW'(MUL_LAT - 1);
            end
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            state    <= S_DONE;
            result_q <= mul_res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          rem_q <= r_nxt;
          quo_q <= q_nxt;
          if (cnt == '0) begin
            state    <= S_DONE;
            result_q <= div_res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall  = rst_n && !flush &&
                  ((state == S_IDLE && md_valid) || state == S_MUL || state == S_DIV);
  assign busy   = (state == S_MUL) || (state == S_DIV);
  assign done   = (state == S_DONE);
  assign result = result_q;

endmodule

// File: rtl/ex_stage_muldiv.sv
// Execute stage: operand forwarding, source muxes, base ALU, and the multi-cycle mul/div unit.
// Build macro EX_DIV_EARLY_OUT_EN (see muldiv_unit) shortens divide-by-zero/overflow stalls.
module ex_stage_muldiv
  import ex_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      ALUCode_ex,
  input  logic            ALUSrcA_ex,
  input  logic [1:0]      ALUSrcB_ex,
  input  logic [XLEN-1:0] Imm_ex,
  input  logic [XLEN-1:0] PC_ex,
  input  logic [4:0]      rs1Addr_ex,
  input  logic [4:0]      rs2Addr_ex,
  input  logic [XLEN-1:0] rs1Data_ex,
  input  logic [XLEN-1:0] rs2Data_ex,
  input  logic [XLEN-1:0] ALUResult_mem,
  input  logic [4:0]      rdAddr_mem,
  input  logic            RegWrite_mem,
  input  logic [XLEN-1:0] RegWriteData_wb,
  input  logic [4:0]      rdAddr_wb,
  input  logic            RegWrite_wb,
  input  logic            MdValid_ex,
  input  logic [2:0]      MdOp_ex,
  input  logic            Flush_ex,
  output logic [XLEN-1:0] ALUResult_ex,
  output logic [XLEN-1:0] MemWriteData_ex,
  output logic [XLEN-1:0] ALU_A,
  output logic [XLEN-1:0] ALU_B,
  output logic            Stall_ex,
  output logic            MdBusy
);

  localparam int unsigned SW = $clog2(XLEN);

  fwd_sel_e        fwd_a, fwd_b;
  logic [XLEN-1:0] fwd_a_data, fwd_b_data, alu_result, md_result;
  logic [SW-1:0]   shamt;
  logic            md_done;

  assign fwd_a = fwd_select(rs1Addr_ex, RegWrite_mem, rdAddr_mem, RegWrite_wb, rdAddr_wb);
  assign fwd_b = fwd_select(rs2Addr_ex, RegWrite_mem, rdAddr_mem, RegWrite_wb, rdAddr_wb);

  always_comb begin
    case (fwd_a)
      FWD_MEM: fwd_a_data = ALUResult_mem;
      FWD_WB:  fwd_a_data = RegWriteData_wb;
      default: fwd_a_data = rs1Data_ex;
    endcase
    case (fwd_b)
      FWD_MEM: fwd_b_data = ALUResult_mem;
      FWD_WB:  fwd_b_data = RegWriteData_wb;
      default: fwd_b_data = rs2Data_ex;
    endcase
  end

  assign MemWriteData_ex = fwd_b_data;
  assign ALU_A           = ALUSrcA_ex ? PC_ex : fwd_a_data;

  always_comb begin
    case (ALUSrcB_ex)
      2'd0:    ALU_B = fwd_b_data;
      2'd1:    ALU_B = Imm_ex;
      2'd2:    ALU_B = XLEN'(4);
      default: ALU_B = '0;
    endcase
  end

  assign shamt = ALU_B[SW-1:0];

  always_comb begin
    case (alu_code_e'(ALUCode_ex))
      ALU_ADD:  alu_result = ALU_A + ALU_B;
      ALU_SUB:  alu_result = ALU_A - ALU_B;
      ALU_SLL:  alu_result = ALU_A << shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(ALU_A) < $signed(ALU_B)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, ALU_A < ALU_B};
      ALU_XOR:  alu_result = ALU_A ^ ALU_B;
      ALU_SRL:  alu_result = ALU_A >> shamt;
      ALU_SRA:  alu_result = $signed(ALU_A) >>> shamt;
      ALU_OR:   alu_result = ALU_A | ALU_B;
      ALU_AND:  alu_result = ALU_A & ALU_B;
      ALU_LUI:  alu_result = ALU_B;
      default:  alu_result = '0;
    endcase
  end

  muldiv_unit #(
    .XLEN    (XLEN),
    .MUL_LAT (MUL_LAT)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_valid (MdValid_ex),
    .md_op    (MdOp_ex),
    .flush    (Flush_ex),
    .op_a     (fwd_a_data),
    .op_b     (fwd_b_data),
    .stall    (Stall_ex),
    .busy     (MdBusy),
    .done     (md_done),
    .result   (md_result)
  );

  assign ALUResult_ex = md_done ? md_result : alu_result;

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed bench for ex_stage_muldiv (XLEN=32, MUL_LAT=2); honours EX_DIV_EARLY_OUT_EN.
module tb_ex_stage_muldiv;
  import ex_pkg::*;

`ifdef EX_DIV_EARLY_OUT_EN
  localparam int SPECIAL_STALL = 1;
`else
  localparam int SPECIAL_STALL = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ALUCode_ex;
  logic        ALUSrcA_ex;
  logic [1:0]  ALUSrcB_ex;
  logic [31:0] Imm_ex, PC_ex;
  logic [4:0]  rs1Addr_ex, rs2Addr_ex;
  logic [31:0] rs1Data_ex, rs2Data_ex;
  logic [31:0] ALUResult_mem;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem;
  logic [31:0] RegWriteData_wb;
  logic [4:0]  rdAddr_wb;
  logic        RegWrite_wb;
  logic        MdValid_ex;
  logic [2:0]  MdOp_ex;
  logic        Flush_ex;
  logic [31:0] ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B;
  logic        Stall_ex, MdBusy;

  int tests = 0;
  int fails = 0;

  ex_stage_muldiv #(
    .XLEN    (32),
    .MUL_LAT (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ALUCode_ex      (ALUCode_ex),
    .ALUSrcA_ex      (ALUSrcA_ex),
    .ALUSrcB_ex      (ALUSrcB_ex),
    .Imm_ex          (Imm_ex),
    .PC_ex           (PC_ex),
    .rs1Addr_ex      (rs1Addr_ex),
    .rs2Addr_ex      (rs2Addr_ex),
    .rs1Data_ex      (rs1Data_ex),
    .rs2Data_ex      (rs2Data_ex),
    .ALUResult_mem   (ALUResult_mem),
    .rdAddr_mem      (rdAddr_mem),
    .RegWrite_mem    (RegWrite_mem),
    .RegWriteData_wb (RegWriteData_wb),
    .rdAddr_wb       (rdAddr_wb),
    .RegWrite_wb     (RegWrite_wb),
    .MdValid_ex      (MdValid_ex),
    .MdOp_ex         (MdOp_ex),
    .Flush_ex        (Flush_ex),
    .ALUResult_ex    (ALUResult_ex),
    .MemWriteData_ex (MemWriteData_ex),
    .ALU_A           (ALU_A),
    .ALU_B           (ALU_B),
    .Stall_ex        (Stall_ex),
    .MdBusy          (MdBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts an M op at posedge+1, counts stall cycles, checks the DONE result and the return to IDLE.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int n;
    n = 0;
    MdOp_ex    = op;
    rs1Data_ex = a;
    rs2Data_ex = b;
    MdValid_ex = 1'b1;
    #1;
    while (Stall_ex === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, " stall cycles"}, 32'(n), 32'(exp_stall));
    check({tag, " result"}, ALUResult_ex, exp);
    MdValid_ex = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " idle after"}, {30'd0, Stall_ex, MdBusy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ALUCode_ex = ALU_ADD; ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd0;
    Imm_ex = '0; PC_ex = '0;
    rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = 32'd3; rs2Data_ex = 32'd4;
    ALUResult_mem = '0; rdAddr_mem = '0; RegWrite_mem = 1'b0;
    RegWriteData_wb = '0; rdAddr_wb = '0; RegWrite_wb = 1'b0;
    MdValid_ex = 1'b1; MdOp_ex = MD_DIV; Flush_ex = 1'b0;
    #2;
    check("reset stall", {31'd0, Stall_ex}, 32'd0);
    check("reset busy", {31'd0, MdBusy}, 32'd0);
    check("reset alu add", ALUResult_ex, 32'd7);
    MdValid_ex = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Forwarding
    rs1Addr_ex = 5'd5; rs2Addr_ex = 5'd6;
    rdAddr_mem = 5'd5; rdAddr_wb = 5'd5; RegWrite_mem = 1'b1; RegWrite_wb = 1'b1;
    ALUResult_mem = 32'h100; RegWriteData_wb = 32'h200;
    rs1Data_ex = 32'h300; rs2Data_ex = 32'h10;
    #1;
    check("fwd mem priority A", ALU_A, 32'h100);
    check("fwd mem priority sum", ALUResult_ex, 32'h110);
    RegWrite_mem = 1'b0; #1;
    check("fwd wb when mem not writing", ALU_A, 32'h200);
    RegWrite_mem = 1'b1; rs1Addr_ex = 5'd0; rdAddr_mem = 5'd0; rdAddr_wb = 5'd0; #1;
    check("fwd x0 never forwarded", ALU_A, 32'h300);
    rs2Addr_ex = 5'd7; rdAddr_wb = 5'd7; rdAddr_mem = 5'd9; #1;
    check("fwd wb rs2 memwrite", MemWriteData_ex, 32'h200);
    rs2Addr_ex = 5'd9; #1;
    check("fwd mem rs2 aluB", ALU_B, 32'h100);
    ALUSrcA_ex = 1'b1; ALUSrcB_ex = 2'd2; PC_ex = 32'h1000; #1;
    check("pc plus 4", ALUResult_ex, 32'h1004);
    RegWrite_mem = 1'b0; RegWrite_wb = 1'b0; ALUSrcA_ex = 1'b0;
    rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2;

    // Base ALU
    ALUSrcB_ex = 2'd1; ALUCode_ex = ALU_SUB; Imm_ex = 32'hFFFF_FFF0; rs1Data_ex = 32'h20; #1;
    check("sub imm", ALUResult_ex, 32'h30);
    ALUCode_ex = ALU_SRA; Imm_ex = 32'd4; rs1Data_ex = 32'h8000_0000; #1;
    check("sra", ALUResult_ex, 32'hF800_0000);
    ALUCode_ex = ALU_SLT; Imm_ex = 32'd1; rs1Data_ex = 32'hFFFF_FFFF; #1;
    check("slt", ALUResult_ex, 32'd1);
    ALUCode_ex = ALU_SLTU; #1;
    check("sltu", ALUResult_ex, 32'd0);
    ALUCode_ex = ALU_ADD; ALUSrcB_ex = 2'd0;
    @(posedge clk); #1;

    // Multiply / divide
    run_md("mul",      MD_MUL,    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 3);
    run_md("mulh",     MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3);
    run_md("mulhu",    MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
    run_md("mulhsu",   MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 3);
    run_md("div -7/2", MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_md("rem -7/2", MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_md("divu 5/0", MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, SPECIAL_STALL);
    run_md("remu 5/0", MD_REMU,   32'd5,         32'd0,         32'd5,         SPECIAL_STALL);
    run_md("rem -7/0", MD_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SPECIAL_STALL);
    run_md("div ovf",  MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_STALL);
    run_md("rem ovf",  MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPECIAL_STALL);
    run_md("divu 100/7", MD_DIVU, 32'd100,       32'd7,         32'd14,        33);
    run_md("remu 100/7", MD_REMU, 32'd100,       32'd7,         32'd2,         33);

    // Flush at stall cycle 10 of a divide
    MdOp_ex = MD_DIV; rs1Data_ex = 32'hFFFF_FFF9; rs2Data_ex = 32'd2; MdValid_ex = 1'b1; #1;
    check("flush div stall cycle1", {31'd0, Stall_ex}, 32'd1);
    repeat (9) @(posedge clk);
    #1;
    Flush_ex = 1'b1; #1;
    check("flush stall low", {31'd0, Stall_ex}, 32'd0);
    check("flush still busy", {31'd0, MdBusy}, 32'd1);
    @(posedge clk); #1;
    Flush_ex = 1'b0; MdValid_ex = 1'b0; #1;
    check("flush idle busy", {31'd0, MdBusy}, 32'd0);
    check("flush idle stall", {31'd0, Stall_ex}, 32'd0);
    run_md("mul after flush", MD_MUL, 32'd6, 32'd7, 32'd42, 3);

    // Reset at stall cycle 10 of a divide
    MdOp_ex = MD_DIV; rs1Data_ex = 32'hFFFF_FFF9; rs2Data_ex = 32'd2; MdValid_ex = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("pre-reset busy", {31'd0, MdBusy}, 32'd1);
    rst_n = 1'b0; #1;
    check("mid reset stall", {31'd0, Stall_ex}, 32'd0);
    check("mid reset busy", {31'd0, MdBusy}, 32'd0);
    check("mid reset alu", ALUResult_ex, 32'hFFFF_FFFB);
    MdValid_ex = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_md("divu after reset", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
